// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV64 funct3 size/sign encodings
//   - LSU FSM state type
//   - access-latency limit and matching counter width
//   - size_mask(): byte-lane mask for an access size before lane shifting
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // LAT must lie in 1..LAT_MAX; the counter only ever holds LAT-1 downwards.
   localparam int unsigned LAT_MAX = 15;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_t;

   // funct3[1:0] encodes log2 of the access size in bytes.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         2'b10:   return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational alignment datapath of the LSU.
// Ports:
//   off        in   byte offset within the 8-byte word (addr[2:0])
//   funct3     in   RV64 size/sign encoding
//   is_load    in   op is a load
//   is_store   in   op is a store
//   wdata      in   LSB-justified store data
//   rdata      in   raw 8-byte word read from memory
//   err        out  misaligned, illegal funct3, or load+store both set
//   wmask      out  byte-lane write mask
//   wdata_lane out  store data shifted onto its byte lanes
//   rdata_ext  out  load data extracted from its lanes and extended
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 64
)
(
   input  logic [2:0]      off,
   input  logic [2:0]      funct3,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic            err,
   output logic [7:0]      wmask,
   output logic [XLEN-1:0] wdata_lane,
   output logic [XLEN-1:0] rdata_ext
);

   logic            misalign;
   logic            illegal;
   logic [XLEN-1:0] shifted;

   always_comb begin
      case (funct3[1:0])
         2'b01:   misalign = off[0];
         2'b10:   misalign = |off[1:0];
         2'b11:   misalign = |off;
         default: misalign = 1'b0;
      endcase

      // 11x has no store form; 111 has no form at all.
      illegal = (funct3 == 3'b111)
             || (is_store && (funct3[2:1] == 2'b11))
             || (is_load && is_store);

      // Only memory ops can fault; a non-memory op passes straight through.
      err = (is_load || is_store) && (misalign || illegal);

      wmask      = size_mask(funct3[1:0]) << off;
      wdata_lane = wdata << {off, 3'b000};
      shifted    = rdata >> {off, 3'b000};

      case (funct3)
         F3_B:    rdata_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         F3_H:    rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_W:    rdata_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_BU:   rdata_ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
         F3_HU:   rdata_ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
         F3_WU:   rdata_ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the execute stage and data memory.
// Accepts one op at a time, drives an 8-byte-aligned memory access held for
// LAT cycles, and returns extended load data (or an error) to writeback.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          op handshake from execute
//   in_addr, in_wdata          effective byte address, LSB-justified store data
//   in_funct3                  RV64 size/sign encoding
//   in_is_load, in_is_store    op kind
//   mem_raddr/mem_ren          aligned read address and read enable
//   mem_rdata                  read data from memory
//   mem_waddr/mem_wdata        aligned write address, lane-shifted store data
//   mem_wmask/mem_wen          byte-lane mask and single-cycle write strobe
//   out_valid/out_ready        result handshake to writeback
//   out_rdata, out_err         extended load data (0 for stores), error flag
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int unsigned LAT  = 1,
   parameter int unsigned XLEN = 64
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [2:0]      in_funct3,
   input  logic            in_is_load,
   input  logic            in_is_store,
   output logic [XLEN-1:0] mem_raddr,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            mem_ren,
   output logic [XLEN-1:0] mem_waddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [7:0]      mem_wmask,
   output logic            mem_wen,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rdata,
   output logic            out_err
);

   lsu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       off_q;
   logic [2:0]       f3_q;
   logic             ld_q;
   logic             st_q;

   logic             a_ld;
   logic             a_st;
   logic [2:0]       a_off;
   logic [2:0]       a_f3;
   logic             al_err;
   logic [7:0]       al_wmask;
   logic [XLEN-1:0]  al_wdata;
   logic [XLEN-1:0]  al_rdata;

   assign in_ready = (state == IDLE);

   // One aligner serves both phases: while idle it screens the incoming op
   // and builds the store lanes; afterwards it extracts load data for the
   // captured op.
   always_comb begin
      a_off = in_ready ? in_addr[2:0] : off_q;
      a_f3  = in_ready ? in_funct3    : f3_q;
      a_ld  = in_ready ? in_is_load   : ld_q;
      a_st  = in_ready ? in_is_store  : st_q;
   end

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .off        (a_off),
      .funct3     (a_f3),
      .is_load    (a_ld),
      .is_store   (a_st),
      .wdata      (in_wdata),
      .rdata      (mem_rdata),
      .err        (al_err),
      .wmask      (al_wmask),
      .wdata_lane (al_wdata),
      .rdata_ext  (al_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         off_q     <= '0;
         f3_q      <= '0;
         ld_q      <= 1'b0;
         st_q      <= 1'b0;
         mem_raddr <= '0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         out_valid <= 1'b0;
         out_rdata <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  off_q <= in_addr[2:0];
                  f3_q  <= in_funct3;
                  ld_q  <= in_is_load;
                  st_q  <= in_is_store;
                  if (al_err) begin
                     state     <= RESP;
                     out_valid <= 1'b1;
                     out_err   <= 1'b1;
                     out_rdata <= '0;
                  end else if (!in_is_load && !in_is_store) begin
                     state     <= RESP;
                     out_valid <= 1'b1;
                     out_err   <= 1'b0;
                     out_rdata <= '0;
                  end else begin
                     state     <= ACCESS;
                     cnt       <= CNT_W'(LAT - 1);
                     mem_raddr <= {in_addr[XLEN-1:3], 3'b000};
                     mem_waddr <= {in_addr[XLEN-1:3], 3'b000};
                     mem_wdata <= al_wdata;
                     mem_wmask <= in_is_store ? al_wmask : 8'h00;
                     mem_ren   <= in_is_load;
                     mem_wen   <= in_is_store;
                  end
               end
            end

            ACCESS: begin
               // The write strobe only lives for the first access cycle.
               mem_wen <= 1'b0;
               if (cnt == '0) begin
                  state     <= RESP;
                  out_valid <= 1'b1;
                  out_err   <= 1'b0;
                  out_rdata <= ld_q ? al_rdata : '0;
                  mem_ren   <= 1'b0;
                  mem_wmask <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            RESP: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_err   <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_unit.sv
module tb_lsu_unit;
   import lsu_pkg::*;

   localparam int LAT = 3;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic [2:0]  in_funct3;
   logic        in_is_load;
   logic        in_is_store;
   logic [63:0] mem_raddr;
   logic [63:0] mem_rdata;
   logic        mem_ren;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_wen;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_rdata;
   logic        out_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Backing store for 0x80000000..0x8000003F, shared by memory and model.
   bit [63:0] mem [8];
   assign mem_rdata = mem[mem_raddr[5:3]];

   // Transaction-level expectation of the current op.
   int          m_acc;   // access cycles still to run, 0 when not accessing
   bit          m_resp;  // a response is expected on the output
   bit          m_ld;
   bit          m_st;
   logic [63:0] m_addr;
   logic [7:0]  m_mask;
   logic [63:0] m_wd;
   logic [63:0] m_rd;
   bit          m_err;
   logic        m_idle;
   assign m_idle = (m_acc == 0) && !m_resp;

   lsu_unit #(.LAT(LAT), .XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_ren(mem_ren),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_wen(mem_wen),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata(out_rdata), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit exp_err(input logic [63:0] a, input logic [2:0] f3, input bit ld, input bit st);
      if (!ld && !st) return 1'b0;
      if (ld && st) return 1'b1;
      if (f3 == 3'd7) return 1'b1;
      if (st && f3 >= 3'd6) return 1'b1;
      return (a % 64'(nbytes(f3))) != 64'd0;
   endfunction

   function automatic logic [7:0] exp_mask(input logic [63:0] a, input logic [2:0] f3);
      int off = int'(a % 64'd8);
      return 8'(((1 << nbytes(f3)) - 1) << off);
   endfunction

   function automatic logic [63:0] exp_load(input logic [63:0] word, input logic [63:0] a, input logic [2:0] f3);
      int n = nbytes(f3);
      int off = int'(a % 64'd8);
      logic [63:0] v;
      logic [63:0] keep;
      v = word >> (8 * off);
      if (n == 8) return v;
      keep = (64'd1 << (8 * n)) - 64'd1;
      v = v & keep;
      if (f3 < 3'd4 && v[8*n-1]) v = v | ~keep;
      return v;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] mask, input logic [63:0] data);
      logic [63:0] r = old;
      for (int i = 0; i < 8; i++)
         if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
      return r;
   endfunction

   // Reference model: advances on the same inputs the DUT sees.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc  <= 0;
         m_resp <= 1'b0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_ld   <= in_is_load;
            m_st   <= in_is_store;
            m_addr <= in_addr;
            m_mask <= exp_mask(in_addr, in_funct3);
            m_wd   <= in_wdata << (8 * int'(in_addr % 64'd8));
            m_err  <= exp_err(in_addr, in_funct3, in_is_load, in_is_store);
            if (exp_err(in_addr, in_funct3, in_is_load, in_is_store) || (!in_is_load && !in_is_store)) begin
               m_resp <= 1'b1;
               m_rd   <= 64'd0;
            end else begin
               m_acc <= LAT;
               m_rd  <= in_is_load ? exp_load(mem[in_addr[5:3]], in_addr, in_funct3) : 64'd0;
               if (in_is_store)
                  mem[in_addr[5:3]] <= merge(mem[in_addr[5:3]], exp_mask(in_addr, in_funct3),
                                             in_wdata << (8 * int'(in_addr % 64'd8)));
            end
         end
      end else if (m_acc > 0) begin
         m_acc <= m_acc - 1;
         if (m_acc == 1) m_resp <= 1'b1;
      end else if (out_ready) begin
         m_resp <= 1'b0;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, m_idle);
         chk("out_valid", out_valid, m_resp);
         chk("mem_ren", mem_ren, (m_acc > 0) && m_ld);
         chk("mem_wen", mem_wen, (m_acc == LAT) && m_st);
         chk("mem_wmask", mem_wmask, ((m_acc > 0) && m_st) ? m_mask : 8'h00);
         if (m_acc > 0) begin
            chk("mem_raddr", mem_raddr, m_addr & ~64'h7);
            chk("mem_waddr", mem_waddr, m_addr & ~64'h7);
            if (m_st && m_acc == LAT) chk("mem_wdata", mem_wdata, m_wd);
         end
         if (m_resp) begin
            chk("out_rdata", out_rdata, m_rd);
            chk("out_err", out_err, m_err);
         end
      end
   end

   int          lat, wens, rens, ov;
   logic [63:0] rd, wdt, ra, wa;
   logic        err;
   logic [7:0]  wm;

   task automatic wait_idle();
      int guard = 0;
      while (!m_idle && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      chk("wait_idle_timeout", {63'd0, m_idle}, 64'd1);
   endtask

   // Issue one op, observe its memory activity and response, hold the
   // response for 'hold' cycles, then accept it.
   task automatic op(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] f3,
                     input logic ld, input logic st, input int hold);
      out_ready = 1'b0;
      wait_idle();
      in_valid = 1'b1; in_addr = a; in_wdata = wd; in_funct3 = f3;
      in_is_load = ld; in_is_store = st;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1; wens = 0; rens = 0; wm = 8'h00; wdt = '0; ra = '0; wa = '0;
      while (!out_valid && lat < 40) begin
         if (mem_wen) begin wens++; wm = mem_wmask; wdt = mem_wdata; wa = mem_waddr; end
         if (mem_ren) begin rens++; ra = mem_raddr; end
         @(negedge clk);
         lat++;
      end
      chk("op_timeout", {63'd0, out_valid}, 64'd1);
      for (int i = 0; i < hold; i++) @(negedge clk);
      rd = out_rdata;
      err = out_err;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
      in_is_load = 1'b0; in_is_store = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rdata", out_rdata, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_mem_raddr", mem_raddr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // SD fills word 0, then LB sign-extends byte 3.
      op(64'h8000_0000, 64'h0000_0000_F000_0000, F3_D, 1'b0, 1'b1, 0);
      chk("sd_wens", wens, 1);
      chk("sd_wmask", wm, 8'hFF);
      chk("sd_rdata", rd, 0);
      op(64'h8000_0003, 64'd0, F3_B, 1'b1, 1'b0, 0);
      chk("lb_rdata", rd, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("lb_raddr", ra, 64'h8000_0000);
      chk("lb_err", err, 0);
      chk("lb_latency", lat, LAT + 1);
      chk("lb_rens", rens, LAT);

      op(64'h8000_0000, 64'h8765_4321_0000_0000, F3_D, 1'b0, 1'b1, 0);
      op(64'h8000_0004, 64'd0, F3_WU, 1'b1, 1'b0, 0);
      chk("lwu_rdata", rd, 64'h0000_0000_8765_4321);
      op(64'h8000_0004, 64'd0, F3_W, 1'b1, 1'b0, 0);
      chk("lw_rdata", rd, 64'hFFFF_FFFF_8765_4321);

      op(64'h8000_0006, 64'h1234, F3_H, 1'b0, 1'b1, 0);
      chk("sh_waddr", wa, 64'h8000_0000);
      chk("sh_wmask", wm, 8'hC0);
      chk("sh_wdata", wdt, 64'h1234_0000_0000_0000);
      chk("sh_wens", wens, 1);

      op(64'h8000_0004, 64'd0, F3_D, 1'b1, 1'b0, 0);
      chk("ld_mis_err", err, 1);
      chk("ld_mis_rdata", rd, 0);
      chk("ld_mis_latency", lat, 1);
      chk("ld_mis_access", rens + wens, 0);

      // Response held under backpressure.
      op(64'h8000_0006, 64'd0, F3_HU, 1'b1, 1'b0, 5);
      chk("bp_rdata", rd, 64'h1234);
      chk("bp_in_ready_after", in_ready, 1);

      // Reset during the first access cycle of a store.
      wait_idle();
      in_valid = 1'b1; in_addr = 64'h8000_0008; in_wdata = 64'h1122_3344_5566_7788;
      in_funct3 = F3_D; in_is_load = 1'b0; in_is_store = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_pre_wen", mem_wen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_wen", mem_wen, 0);
      chk("rst_async_ren", mem_ren, 0);
      chk("rst_async_wmask", mem_wmask, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ov = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) ov++;
      end
      chk("rst_no_resp", ov, 0);
      op(64'h8000_0006, 64'd0, F3_B, 1'b1, 1'b0, 0);
      chk("post_rst_lb", rd, 64'h34);
      chk("post_rst_err", err, 0);

      // Randomized traffic, including offers while busy.
      for (int c = 0; c < 4000; c++) begin
         int kind;
         @(negedge clk);
         kind = $urandom_range(0, 9);
         in_valid    = ($urandom_range(0, 2) != 0);
         in_is_load  = (kind == 1) || (kind >= 2 && kind <= 5);
         in_is_store = (kind == 1) || (kind >= 6);
         in_funct3   = (kind == 0) ? F3_B : 3'($urandom_range(0, 7));
         in_addr     = 64'h8000_0000 + 64'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            in_addr = in_addr & ~64'(nbytes(in_funct3) - 1);
         in_wdata    = {$urandom, $urandom};
         out_ready   = ($urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      @(negedge clk);
      chk("drain_in_ready", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
